ines_stream_loader: RTL and testbench
=====================================

// Module: ines_stream_loader
// PURPOSE
//  Consumer end of the SD ROM byte stream: takes the unthrottled dout/dout_valid bytes of a .nes file,
//  parses and checks the 16-byte iNES header and skips the optional 512-byte trainer.
//  Buffers the PRG then CHR payload and writes it to cartridge memory over a ready/valid write port.
//  Publishes mapper/mirroring/bank info to the NES core and signals done/error to the top level.
// PARAMETERS
//  FIFO_DEPTH  16        payload buffer entries, power of two >= 4
//  ADDR_W      22        memory byte-address width
//  CHR_BASE    22'h200000 byte address of CHR region; PRG region is [0, CHR_BASE)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high; also restarts a load
//  din          in   8   stream byte
//  din_valid    in   1   1-cycle strobe per byte, no backpressure
//  mem_addr     out  ADDR_W write byte address
//  mem_data     out  8   write data
//  mem_write    out  1   write request, held until accepted
//  mem_ready    in   1   write accepted this cycle when mem_write&mem_ready
//  prg_banks    out  8   header byte 4 (16 KiB units)
//  chr_banks    out  8   header byte 5 (8 KiB units; 0 = CHR RAM)
//  mapper       out  8   {byte7[7:4], byte6[7:4]}
//  mirroring    out  1   byte6[0]
//  battery      out  1   byte6[1]
//  header_ok    out  1   header fields valid, sticky until reset
//  done         out  1   all payload written to memory, sticky
//  error        out  2   0 none, 1 bad magic, 2 FIFO overflow, 3 bad size; sticky
//  checksum     out  16  payload sum (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state HDR, byte counters 0, FIFO empty; reset mid-load discards everything.
//  States: HDR -> (TRAIN) -> PRG -> (CHR) -> DONE; any error -> FAIL. FAIL/DONE ignore din_valid.
//  HDR: count 16 bytes; bytes 0..3 must be 4E 45 53 1A, first mismatch -> FAIL, error=1 next cycle.
//   byte 4 ==0 or byte4*16384 > CHR_BASE -> FAIL, error=3 (checked when byte 15 arrives).
//   On byte 15: latch fields, header_ok=1 next cycle; go TRAIN if byte6[2] else PRG.
//  TRAIN: drop exactly 512 bytes, then PRG.
//  PRG: push prg_banks*16384 bytes; then CHR if chr_banks!=0 else DONE.
//  CHR: push chr_banks*8192 bytes; then DONE. Bytes beyond the last payload byte are ignored.
//  Payload counters are ADDR_W+1 bits; comparison against full size, no wrap.
//  FIFO: push on din_valid in PRG/CHR; entry = {addr, data}; PRG addr = offset,
//   CHR addr = CHR_BASE + offset (truncated to ADDR_W).
//  Push while full (and no pop same cycle) -> FAIL, error=2; push+pop same cycle when full is legal.
//  mem_write = !fifo_empty; mem_addr/mem_data = FIFO head, stable while mem_write&!mem_ready.
//  Pop on mem_write&mem_ready. In FAIL, FIFO is flushed and mem_write forced 0.
//  done=1 the cycle after state==DONE and FIFO empty; done and error never both set.
//  Latency: byte accepted at cycle n appears on mem port at n+1 earliest (registered FIFO read).
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: checksum = 16-bit wrap-around sum of every PRG+CHR byte pushed,
//   excluding header and trainer; updated cycle after push; cleared on reset.
//  Not defined: checksum tied to 16'h0, no adder logic.
// TESTING
//  1 header 4E 45 53 1A 01 01 01 00 +8x00, 16384 PRG + 8192 CHR, mem_ready=1 -> 24576 writes,
//    PRG addr 0..3FFF, CHR 200000..201FFF, mapper=0, mirroring=1, done=1, error=0.
//  2 byte6=04 (trainer), PRG=1,CHR=0 -> 512 trainer bytes never written, first write addr 0 carries
//    byte 528 of stream, done after 16384 writes.
//  3 byte1=46 -> error=1, header_ok=0, mem_write never asserted.
//  4 byte4=0 -> error=3; byte4=0x81 with CHR_BASE=200000 -> error=3.
//  5 mem_ready=0 held, din_valid every cycle -> FIFO_DEPTH writes buffered, next push -> error=2,
//    mem_write drops; with mem_ready toggling 1/0 at din rate 1/4 -> no error, in-order addresses.
//  6 reset asserted mid-PRG then clean file replay -> identical result to 1;
//    LOADER_CHECKSUM_EN with payload all 01 (PRG=1,CHR=0) -> checksum=16'h4000.

Source files
------------

// File: rtl/ines_stream_loader.sv
// ines_stream_loader: parses an iNES byte stream and writes PRG/CHR payload to memory.
// Optional payload checksum is built when LOADER_CHECKSUM_EN is defined.
module ines_stream_loader #(
    parameter int                FIFO_DEPTH = 16,
    parameter int                ADDR_W     = 22,
    parameter logic [ADDR_W-1:0] CHR_BASE   = 22'h200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_write,
    input  logic              mem_ready,
    output logic [7:0]        prg_banks,
    output logic [7:0]        chr_banks,
    output logic [7:0]        mapper,
    output logic              mirroring,
    output logic              battery,
    output logic              header_ok,
    output logic              done,
    output logic [1:0]        error,
    output logic [15:0]       checksum
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = PW + 1;
    localparam int CW    = ADDR_W + 1;
    localparam int EW    = ADDR_W + 8;

    typedef enum logic [2:0] {
        S_HDR,
        S_TRAIN,
        S_PRG,
        S_CHR,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        hdr_cnt_q, hdr_cnt_d;
    logic [8:0]        trn_cnt_q, trn_cnt_d;
    logic [CW-1:0]     pay_cnt_q, pay_cnt_d;
    logic [7:0]        prg_raw_q, prg_raw_d;
    logic [7:0]        chr_raw_q, chr_raw_d;
    logic [6:0]        f6_q, f6_d;
    logic [3:0]        f7_q, f7_d;
    logic [7:0]        prg_banks_q, prg_banks_d;
    logic [7:0]        chr_banks_q, chr_banks_d;
    logic [7:0]        mapper_q, mapper_d;
    logic              mirroring_q, mirroring_d;
    logic              battery_q, battery_d;
    logic              header_ok_q, header_ok_d;
    logic              done_q, done_d;
    logic [1:0]        error_q, error_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]     fifo_q [FIFO_DEPTH];

    logic              push;
    logic              push_ok;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_W-1:0] push_addr;
    logic [7:0]        magic_b;
    logic [CW-1:0]     pay_next;
    logic [31:0]       prg_size;
    logic [31:0]       chr_size;
    logic [EW-1:0]     head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = fifo_q[rd_ptr_q[PW-1:0]];
    assign mem_write  = !fifo_empty && (state_q != S_FAIL);
    assign mem_addr   = mem_write ? head[EW-1:8] : '0;
    assign mem_data   = mem_write ? head[7:0] : 8'h00;
    assign pop        = mem_write && mem_ready;

    assign pay_next = pay_cnt_q + CW'(1);
    assign prg_size = {24'd0, prg_banks_q} << 14;
    assign chr_size = {24'd0, chr_banks_q} << 13;

    always_comb begin
        unique case (hdr_cnt_q[1:0])
            2'd0: magic_b = 8'h4E;
            2'd1: magic_b = 8'h45;
            2'd2: magic_b = 8'h53;
            2'd3: magic_b = 8'h1A;
            default: magic_b = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        trn_cnt_d   = trn_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        prg_raw_d   = prg_raw_q;
        chr_raw_d   = chr_raw_q;
        f6_d        = f6_q;
        f7_d        = f7_q;
        prg_banks_d = prg_banks_q;
        chr_banks_d = chr_banks_q;
        mapper_d    = mapper_q;
        mirroring_d = mirroring_q;
        battery_d   = battery_q;
        header_ok_d = header_ok_q;
        done_d      = done_q;
        error_d     = error_q;
        push        = 1'b0;
        push_addr   = '0;

        unique case (state_q)
            S_HDR: begin
                if (din_valid) begin
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q < 4'd4 && din != magic_b) begin
                        state_d = S_FAIL;
                        error_d = 2'd1;
                    end
                    case (hdr_cnt_q)
                        4'd4: prg_raw_d = din;
                        4'd5: chr_raw_d = din;
                        4'd6: f6_d = {din[7:4], din[2:0]};
                        4'd7: f7_d = din[7:4];
                        4'd15: begin
                            if (prg_raw_q == 8'd0 ||
                                ({24'd0, prg_raw_q} << 14) > 32'(CHR_BASE)) begin
                                state_d = S_FAIL;
                                error_d = 2'd3;
                            end else begin
                                header_ok_d = 1'b1;
                                prg_banks_d = prg_raw_q;
                                chr_banks_d = chr_raw_q;
                                mapper_d    = {f7_q, f6_q[6:3]};
                                mirroring_d = f6_q[0];
                                battery_d   = f6_q[1];
                                state_d     = f6_q[2] ? S_TRAIN : S_PRG;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_TRAIN: begin
                if (din_valid) begin
                    trn_cnt_d = trn_cnt_q + 9'd1;
                    if (trn_cnt_q == 9'd511) state_d = S_PRG;
                end
            end
            S_PRG: begin
                if (din_valid) begin
                    push      = 1'b1;
                    push_addr = pay_cnt_q[ADDR_W-1:0];
                    pay_cnt_d = pay_next;
                    if (32'(pay_next) == prg_size) begin
                        pay_cnt_d = '0;
                        state_d   = (chr_banks_q != 8'd0) ? S_CHR : S_DONE;
                    end
                end
            end
            S_CHR: begin
                if (din_valid) begin
                    push      = 1'b1;
                    push_addr = CHR_BASE + pay_cnt_q[ADDR_W-1:0];
                    pay_cnt_d = pay_next;
                    if (32'(pay_next) == chr_size) begin
                        pay_cnt_d = '0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (fifo_empty) done_d = 1'b1;
            end
            S_FAIL: ;
            default: state_d = S_FAIL;
        endcase

        // a simultaneous pop frees the slot, so a full FIFO only overflows without one
        push_ok = push && !(fifo_full && !pop);
        if (push && fifo_full && !pop) begin
            state_d = S_FAIL;
            error_d = 2'd2;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        if (state_q == S_FAIL) rd_ptr_d = wr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HDR;
            hdr_cnt_q   <= '0;
            trn_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            prg_raw_q   <= '0;
            chr_raw_q   <= '0;
            f6_q        <= '0;
            f7_q        <= '0;
            prg_banks_q <= '0;
            chr_banks_q <= '0;
            mapper_q    <= '0;
            mirroring_q <= 1'b0;
            battery_q   <= 1'b0;
            header_ok_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            trn_cnt_q   <= trn_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            prg_raw_q   <= prg_raw_d;
            chr_raw_q   <= chr_raw_d;
            f6_q        <= f6_d;
            f7_q        <= f7_d;
            prg_banks_q <= prg_banks_d;
            chr_banks_q <= chr_banks_d;
            mapper_q    <= mapper_d;
            mirroring_q <= mirroring_d;
            battery_q   <= battery_d;
            header_ok_q <= header_ok_d;
            done_q      <= done_d;
            error_q     <= error_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q[PW-1:0]] <= {push_addr, din};
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset) csum_q <= '0;
        else if (push_ok) csum_q <= csum_q + {8'd0, din};
    end

    assign checksum = csum_q;
`else
    assign checksum = 16'h0;
`endif

    assign prg_banks = prg_banks_q;
    assign chr_banks = chr_banks_q;
    assign mapper    = mapper_q;
    assign mirroring = mirroring_q;
    assign battery   = battery_q;
    assign header_ok = header_ok_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_ines_stream_loader.sv
// Scoreboard bench for ines_stream_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every accepted memory write.
module tb_ines_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;
    logic        mem_ready = 1'b1;
    logic [7:0]  prg_banks, chr_banks, mapper;
    logic        mirroring, battery, header_ok, done;
    logic [1:0]  error;
    logic [15:0] checksum;

    int          n_chk = 0;
    int          n_fail = 0;
    int          wcount = 0;
    bit          saw_write = 1'b0;
    logic [15:0] cs_exp = '0;
    logic [29:0] sb [$];

    ines_stream_loader dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
        .mem_ready(mem_ready), .prg_banks(prg_banks), .chr_banks(chr_banks),
        .mapper(mapper), .mirroring(mirroring), .battery(battery),
        .header_ok(header_ok), .done(done), .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_write) saw_write = 1'b1;
            if (mem_write && mem_ready) begin
                logic [29:0] e;
                wcount++;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: got addr %0h data %0h, required no write",
                             mem_addr, mem_data);
                end else begin
                    e = sb.pop_front();
                    if ({mem_addr, mem_data} !== e) begin
                        n_fail++;
                        $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                                 mem_addr, mem_data, e[29:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic put(input logic [7:0] b);
        @(posedge clk);
        #1;
        din = b;
        din_valid = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            din_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        wcount = 0;
        saw_write = 1'b0;
        cs_exp = '0;
    endtask

    task automatic stream(input logic [7:0] b1, input logic [7:0] b4,
                          input logic [7:0] b5, input logic [7:0] b6,
                          input logic [7:0] b7, input int prg_n, input int chr_n,
                          input bit exp_wr, input bit ones, input int spacing);
        int idx;
        logic [7:0] d;
        idx = 0;
        for (int k = 0; k < 16; k++) begin
            case (k)
                0: d = 8'h4E;
                1: d = b1;
                2: d = 8'h53;
                3: d = 8'h1A;
                4: d = b4;
                5: d = b5;
                6: d = b6;
                7: d = b7;
                default: d = 8'h00;
            endcase
            put(d);
            idx++;
        end
        if (b6[2]) begin
            for (int k = 0; k < 512; k++) begin
                put(pat(idx));
                idx++;
            end
        end
        for (int i = 0; i < prg_n + chr_n; i++) begin
            d = ones ? 8'h01 : pat(idx);
            if (exp_wr) begin
                if (i < prg_n) sb.push_back({22'(i), d});
                else sb.push_back({22'h200000 + 22'(i - prg_n), d});
                cs_exp = cs_exp + {8'd0, d};
            end
            put(d);
            idx++;
            if (spacing > 1) gap(spacing - 1);
        end
        gap(1);
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && !done; i++) @(negedge clk);
        chk("done", {31'd0, done}, 32'd1);
    endtask

    task automatic check_cs(input string nm);
        logic [15:0] r;
`ifdef LOADER_CHECKSUM_EN
        r = cs_exp;
`else
        r = 16'h0;
`endif
        chk(nm, {16'd0, checksum}, {16'd0, r});
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_header_ok", {31'd0, header_ok}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {30'd0, error}, 32'd0);
        chk("rst_fields", {prg_banks, chr_banks, mapper, 6'd0, mirroring, battery}, 32'd0);
        chk("rst_checksum", {16'd0, checksum}, 32'd0);
    endtask

    task automatic check_t1(input string tag);
        wait_done(50);
        chk({tag, "_writes"}, wcount, 32'd24576);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
        chk({tag, "_error"}, {30'd0, error}, 32'd0);
        chk({tag, "_header_ok"}, {31'd0, header_ok}, 32'd1);
        chk({tag, "_mapper"}, {24'd0, mapper}, 32'd0);
        chk({tag, "_mirroring"}, {31'd0, mirroring}, 32'd1);
        chk({tag, "_banks"}, {16'd0, prg_banks, chr_banks}, 32'h0101);
        check_cs({tag, "_checksum"});
    endtask

    initial begin
        do_reset();
        check_reset_state();

        // basic PRG+CHR load
        stream(8'h45, 8'h01, 8'h01, 8'h01, 8'h00, 16384, 8192, 1'b1, 1'b0, 1);
        check_t1("t1");

        // trainer skipped, mapper/battery fields
        do_reset();
        stream(8'h45, 8'h01, 8'h00, 8'h46, 8'h30, 16384, 0, 1'b1, 1'b0, 1);
        wait_done(50);
        chk("t2_writes", wcount, 32'd16384);
        chk("t2_sb_empty", sb.size(), 32'd0);
        chk("t2_mapper", {24'd0, mapper}, 32'h34);
        chk("t2_flags", {30'd0, mirroring, battery}, 32'd1);
        chk("t2_chr_banks", {24'd0, chr_banks}, 32'd0);
        chk("t2_error", {30'd0, error}, 32'd0);

        // bad magic
        do_reset();
        stream(8'h46, 8'h01, 8'h01, 8'h00, 8'h00, 32, 0, 1'b0, 1'b0, 1);
        gap(2);
        chk("t3_error", {30'd0, error}, 32'd1);
        chk("t3_header_ok", {31'd0, header_ok}, 32'd0);
        chk("t3_no_write", {31'd0, saw_write}, 32'd0);
        chk("t3_done", {31'd0, done}, 32'd0);

        // bad sizes and the exact-fit boundary
        do_reset();
        stream(8'h45, 8'h00, 8'h01, 8'h00, 8'h00, 8, 0, 1'b0, 1'b0, 1);
        gap(2);
        chk("t4_zero_prg", {30'd0, error}, 32'd3);
        chk("t4_zero_hdr_ok", {31'd0, header_ok}, 32'd0);
        do_reset();
        stream(8'h45, 8'h81, 8'h00, 8'h00, 8'h00, 8, 0, 1'b0, 1'b0, 1);
        gap(2);
        chk("t4_big_prg", {30'd0, error}, 32'd3);
        chk("t4_big_no_write", {31'd0, saw_write}, 32'd0);
        do_reset();
        stream(8'h45, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 1);
        gap(2);
        chk("t4_fit_error", {30'd0, error}, 32'd0);
        chk("t4_fit_hdr_ok", {31'd0, header_ok}, 32'd1);

        // overflow with memory stalled
        do_reset();
        mem_ready = 1'b0;
        stream(8'h45, 8'h01, 8'h00, 8'h00, 8'h00, 16, 0, 1'b0, 1'b0, 1);
        gap(1);
        chk("t5_full_error", {30'd0, error}, 32'd0);
        chk("t5_full_write", {31'd0, mem_write}, 32'd1);
        chk("t5_head_addr", {10'd0, mem_addr}, 32'd0);
        chk("t5_head_data", {24'd0, mem_data}, {24'd0, pat(16)});
        put(8'hAA);
        gap(2);
        chk("t5_ovf_error", {30'd0, error}, 32'd2);
        chk("t5_ovf_write", {31'd0, mem_write}, 32'd0);
        chk("t5_ovf_done", {31'd0, done}, 32'd0);
        mem_ready = 1'b1;

        // throttled memory, slow stream
        do_reset();
        fork
            stream(8'h45, 8'h01, 8'h00, 8'h00, 8'h00, 200, 0, 1'b1, 1'b0, 4);
            repeat (830) begin
                @(posedge clk);
                #1;
                mem_ready = ~mem_ready;
            end
        join
        mem_ready = 1'b1;
        gap(10);
        chk("t5b_error", {30'd0, error}, 32'd0);
        chk("t5b_sb_empty", sb.size(), 32'd0);
        chk("t5b_writes", wcount, 32'd200);

        // reset mid-PRG, then clean replay
        do_reset();
        stream(8'h45, 8'h01, 8'h01, 8'h01, 8'h00, 1000, 0, 1'b1, 1'b0, 1);
        gap(4);
        chk("t6_partial_drained", sb.size(), 32'd0);
        do_reset();
        check_reset_state();
        stream(8'h45, 8'h01, 8'h01, 8'h01, 8'h00, 16384, 8192, 1'b1, 1'b0, 1);
        check_t1("t6");

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        stream(8'h45, 8'h01, 8'h00, 8'h00, 8'h00, 16384, 0, 1'b1, 1'b1, 1);
        wait_done(50);
        chk("t6_cs_ones", {16'd0, checksum}, 32'h4000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
